// File: rtl/receptor_medida_dht11_pkg.sv
// rtl/receptor_medida_dht11_pkg.sv - shared state codes, frame size, baud divisor and checksum rule
package receptor_medida_dht11_pkg;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    PEDE     = 3'd1,
    ESPERA   = 3'd2,
    ARMAZENA = 3'd3,
    VERIFICA = 3'd4,
    PRONTO   = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  typedef enum logic [1:0] {
    RX_OCIOSO,
    RX_INICIO,
    RX_DADOS,
    RX_PARADA
  } estado_rx_t;

  localparam int FRAME_BYTES           = 5;
  localparam int CICLOS_POR_BIT_PADRAO = 434;

  // DHT11 checksum: 8-bit wrap-around sum of the four data bytes
  function automatic logic checksum_ok(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [7:0] b4);
    logic [7:0] soma;
    soma = b0 + b1 + b2 + b3;
    return soma == b4;
  endfunction

endpackage

// File: rtl/rx_serial_8n1.sv
// rtl/rx_serial_8n1.sv - 8N1 serial receiver with mid-bit sampling and stop-bit check
module rx_serial_8n1
  import receptor_medida_dht11_pkg::*;
#(
  parameter int CICLOS_POR_BIT = CICLOS_POR_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       byte_pronto,
  output logic [7:0] dado,
  output logic       erro_stop
);

  localparam int CW = $clog2(CICLOS_POR_BIT + 1);
  localparam logic [CW-1:0] MEIO = CW'(CICLOS_POR_BIT / 2 - 1);
  localparam logic [CW-1:0] FIM  = CW'(CICLOS_POR_BIT - 1);

  logic sync1, sync2, sync3;
  estado_rx_t estado, proximo;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] desloc, desloc_n, dado_n;
  logic byte_pronto_n, erro_stop_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      sync3       <= 1'b1;
      estado      <= RX_OCIOSO;
      cnt         <= '0;
      bit_idx     <= '0;
      desloc      <= '0;
      dado        <= '0;
      byte_pronto <= 1'b0;
      erro_stop   <= 1'b0;
    end else begin
      sync1       <= rx_serial;
      sync2       <= sync1;
      sync3       <= sync2;
      estado      <= proximo;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      desloc      <= desloc_n;
      dado        <= dado_n;
      byte_pronto <= byte_pronto_n;
      erro_stop   <= erro_stop_n;
    end
  end

  always_comb begin
    proximo       = estado;
    cnt_n         = cnt + CW'(1);
    bit_n         = bit_idx;
    desloc_n      = desloc;
    dado_n        = dado;
    byte_pronto_n = 1'b0;
    erro_stop_n   = erro_stop;
    case (estado)
      RX_OCIOSO: begin
        cnt_n = '0;
        if (sync3 && !sync2) proximo = RX_INICIO;
      end
      RX_INICIO: begin
        // a start bit that is high again at mid-bit was a glitch
        if (cnt == MEIO) begin
          cnt_n   = '0;
          bit_n   = '0;
          proximo = sync2 ? RX_OCIOSO : RX_DADOS;
        end
      end
      RX_DADOS: begin
        if (cnt == FIM) begin
          cnt_n    = '0;
          desloc_n = {sync2, desloc[7:1]};
          bit_n    = bit_idx + 3'd1;
          if (bit_idx == 3'd7) proximo = RX_PARADA;
        end
      end
      RX_PARADA: begin
        if (cnt == FIM) begin
          cnt_n         = '0;
          proximo       = RX_OCIOSO;
          byte_pronto_n = 1'b1;
          dado_n        = desloc;
          erro_stop_n   = !sync2;
        end
      end
      default: proximo = RX_OCIOSO;
    endcase
  end

endmodule

// File: rtl/receptor_medida_dht11.sv
// rtl/receptor_medida_dht11.sv - DHT11 measurement request, 5-byte frame capture, checksum and timeout
module receptor_medida_dht11
  import receptor_medida_dht11_pkg::*;
#(
  parameter int CICLOS_POR_BIT = CICLOS_POR_BIT_PADRAO,
  parameter int LARGURA_PULSO  = 50_000,
  parameter int TIMEOUT_CICLOS = 25_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        rx_serial,
  output logic        medir_dht11_out,
  output logic        pronto,
  output logic        erro,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic [2:0]  db_estado
);

  localparam int PW = $clog2(LARGURA_PULSO + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [PW-1:0] PULSO_FIM   = PW'(LARGURA_PULSO - 1);
  localparam logic [TW-1:0] TIMEOUT_FIM = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [2:0]    ULTIMO_IDX  = 3'(FRAME_BYTES - 1);

  estado_t estado, proximo;
  logic [PW-1:0] cnt_pulso;
  logic [TW-1:0] cnt_timeout;
  logic [2:0]    idx;
  logic [7:0]    sombra [FRAME_BYTES];
  logic [7:0]    byte_reg;
  logic          pendente, pendente_erro;
  logic          byte_pronto, erro_stop;
  logic [7:0]    dado;
  logic          quadro_ok;

  rx_serial_8n1 #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .byte_pronto(byte_pronto),
    .dado       (dado),
    .erro_stop  (erro_stop)
  );

  assign quadro_ok = checksum_ok(sombra[0], sombra[1], sombra[2], sombra[3], sombra[4]);
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= INICIAL;
      cnt_pulso     <= '0;
      cnt_timeout   <= '0;
      idx           <= '0;
      byte_reg      <= '0;
      pendente      <= 1'b0;
      pendente_erro <= 1'b0;
      temperatura   <= '0;
      umidade       <= '0;
      for (int i = 0; i < FRAME_BYTES; i++) sombra[i] <= '0;
    end else begin
      estado      <= proximo;
      cnt_pulso   <= (estado == PEDE)   ? cnt_pulso + PW'(1)   : '0;
      cnt_timeout <= (estado == ESPERA) ? cnt_timeout + TW'(1) : '0;
      if ((estado == PEDE || estado == ESPERA) && byte_pronto) byte_reg <= dado;
      // a byte finishing during the request pulse is held until ESPERA consumes it
      if (estado == PEDE) begin
        if (byte_pronto) begin
          pendente      <= 1'b1;
          pendente_erro <= erro_stop;
        end
      end else begin
        pendente      <= 1'b0;
        pendente_erro <= 1'b0;
      end
      if (estado == INICIAL) idx <= '0;
      if (estado == ARMAZENA) begin
        sombra[idx] <= byte_reg;
        if (idx != ULTIMO_IDX) idx <= idx + 3'd1;
      end
      if (estado == VERIFICA && quadro_ok) begin
        umidade     <= {sombra[0], sombra[1]};
        temperatura <= {sombra[2], sombra[3]};
      end
    end
  end

  always_comb begin
    proximo         = estado;
    medir_dht11_out = 1'b0;
    pronto          = 1'b0;
    erro            = 1'b0;
    case (estado)
      INICIAL:  if (medir) proximo = PEDE;
      PEDE: begin
        medir_dht11_out = 1'b1;
        if (cnt_pulso == PULSO_FIM) proximo = ESPERA;
      end
      ESPERA: begin
        // an arriving byte takes precedence over an expiring timeout
        if (byte_pronto)                   proximo = erro_stop ? ERRO : ARMAZENA;
        else if (pendente)                 proximo = pendente_erro ? ERRO : ARMAZENA;
        else if (cnt_timeout == TIMEOUT_FIM) proximo = ERRO;
      end
      ARMAZENA: proximo = (idx == ULTIMO_IDX) ? VERIFICA : ESPERA;
      VERIFICA: proximo = quadro_ok ? PRONTO : ERRO;
      PRONTO: begin
        pronto  = 1'b1;
        proximo = INICIAL;
      end
      ERRO: begin
        pronto  = 1'b1;
        erro    = 1'b1;
        proximo = INICIAL;
      end
      default: proximo = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_receptor_medida_dht11.sv
// tb/tb_receptor_medida_dht11.sv - self-checking bench with a transaction-level model of the DHT11 receiver
module tb_receptor_medida_dht11;

  localparam int CPB = 4;
  localparam int LP  = 3;
  localparam int TO  = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        medir = 1'b0;
  logic        rx_serial = 1'b1;
  logic        medir_dht11_out, pronto, erro;
  logic [15:0] temperatura, umidade;
  logic [2:0]  db_estado;

  receptor_medida_dht11 #(
    .CICLOS_POR_BIT(CPB),
    .LARGURA_PULSO (LP),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .medir          (medir),
    .rx_serial      (rx_serial),
    .medir_dht11_out(medir_dht11_out),
    .pronto         (pronto),
    .erro           (erro),
    .temperatura    (temperatura),
    .umidade        (umidade),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        erro;
    logic [15:0] temp;
    logic [15:0] umid;
  } esperado_t;

  esperado_t   fila[$];
  esperado_t   e_cmp;
  int          n_checks = 0, n_fail = 0, n_pronto = 0, ciclo = 0;
  int          armazena_cyc = 0, erro_cyc = 0, largura_atual = 0, largura_ultima = 0;
  int          pulso_rest = 0;
  bit          ocupado = 0, exp_pulso;
  logic [15:0] exp_temp = 16'h0000, exp_umid = 16'h0000;
  logic [7:0]  q [5];

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, ciclo);
    end
  endtask

  // model: one transaction per accepted request, result popped when pronto shows up
  always @(negedge clock) begin
    ciclo++;
    if (reset) begin
      ocupado       = 0;
      pulso_rest    = 0;
      exp_temp      = 16'h0000;
      exp_umid      = 16'h0000;
      largura_atual = 0;
      fila.delete();
    end else begin
      exp_pulso = (pulso_rest > 0);
      if (exp_pulso) pulso_rest--;
      check("medir_dht11_out", medir_dht11_out, exp_pulso);
      if (!ocupado) check("db_estado_idle", db_estado, 0);
      if (medir && !ocupado) begin
        ocupado    = 1;
        pulso_rest = LP;
      end
      if (db_estado == 3'd3) armazena_cyc = ciclo;
      if (pronto) begin
        n_pronto++;
        if (erro) erro_cyc = ciclo;
        if (fila.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pronto: got pronto=1 expected 0 (cycle %0d)", ciclo);
        end else begin
          e_cmp = fila.pop_front();
          check("erro_at_pronto", erro, e_cmp.erro);
          if (!e_cmp.erro) begin
            exp_temp = e_cmp.temp;
            exp_umid = e_cmp.umid;
          end
        end
        ocupado = 0;
      end else begin
        check("erro_without_pronto", erro, 0);
      end
      check("temperatura", temperatura, exp_temp);
      check("umidade", umidade, exp_umid);
      if (medir_dht11_out) largura_atual++;
      else if (largura_atual != 0) begin
        largura_ultima = largura_atual;
        largura_atual  = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx_serial = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) step();
    end
    rx_serial = stop_ok;
    repeat (CPB) step();
    rx_serial = 1'b1;
    repeat (2) step();
  endtask

  task automatic wait_pronto(input int alvo);
    for (int i = 0; i < 3000; i++) begin
      if (n_pronto >= alvo) break;
      step();
    end
    check("pronto_arrived", n_pronto >= alvo, 1);
  endtask

  task automatic pulse_medir();
    medir = 1'b1;
    step();
    medir = 1'b0;
  endtask

  task automatic transacao(input int n_env, input int idx_ruim, input bit medir_extra, input bit esperar);
    esperado_t e;
    int soma, alvo;
    soma   = q[0] + q[1] + q[2] + q[3];
    e.temp = {q[2], q[3]};
    e.umid = {q[0], q[1]};
    e.erro = (n_env < 5) || (idx_ruim < n_env) || ((soma % 256) != q[4]);
    fila.push_back(e);
    alvo = n_pronto + 1;
    pulse_medir();
    repeat ($urandom_range(0, 6)) step();
    for (int i = 0; i < n_env; i++) begin
      send_byte(q[i], i != idx_ruim);
      if (i == idx_ruim) break;
      if (medir_extra && i == 0) pulse_medir();
      repeat ($urandom_range(0, 12)) step();
    end
    if (esperar) wait_pronto(alvo);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int modo, antes;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_temperatura", temperatura, 16'h0000);
    check("reset_umidade", umidade, 16'h0000);
    check("reset_db_estado", db_estado, 0);
    check("reset_pronto", pronto, 0);
    check("reset_medir_out", medir_dht11_out, 0);

    q = '{8'h37, 8'h00, 8'h19, 8'h05, 8'h55};
    transacao(5, 9, 0, 1);
    step();
    check("s1_temperatura", temperatura, 16'h1905);
    check("s1_umidade", umidade, 16'h3700);
    check("s1_pulse_width", largura_ultima, 3);

    q = '{8'h40, 8'h00, 8'h1A, 8'h00, 8'h00};
    transacao(5, 9, 0, 1);
    step();
    check("s2_erro_seen", erro_cyc > armazena_cyc, 1);
    check("s2_temperatura", temperatura, 16'h1905);
    check("s2_umidade", umidade, 16'h3700);

    q = '{8'hFF, 8'h01, 8'h80, 8'h80, 8'h00};
    transacao(5, 9, 0, 1);
    step();
    check("s4_temperatura", temperatura, 16'h8080);
    check("s4_umidade", umidade, 16'hFF01);

    q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
    transacao(3, 9, 0, 1);
    step();
    check("s3_timeout_cycles_after_armazena", erro_cyc - (armazena_cyc + 1), TO);
    check("s3_temperatura", temperatura, 16'h8080);
    check("s3_db_estado", db_estado, 0);

    send_byte(8'h11, 1'b1);
    repeat (5) step();
    antes = n_pronto;
    q = '{8'h30, 8'h02, 8'h17, 8'h04, 8'h4D};
    transacao(5, 9, 1, 1);
    repeat (60) step();
    check("s5_single_pronto", n_pronto, antes + 1);
    check("s5_temperatura", temperatura, 16'h1704);

    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    transacao(3, 9, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s6_temperatura", temperatura, 16'h0000);
    check("s6_umidade", umidade, 16'h0000);
    check("s6_db_estado", db_estado, 0);
    check("s6_pronto", pronto, 0);
    q = '{8'h2A, 8'h05, 8'h1C, 8'h03, 8'h4E};
    transacao(5, 9, 0, 1);
    step();
    check("s6_new_temperatura", temperatura, 16'h1C03);
    check("s6_new_umidade", umidade, 16'h2A05);

    for (int k = 0; k < 8; k++) begin
      modo = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) q[i] = 8'($urandom);
      q[4] = q[0] + q[1] + q[2] + q[3];
      if (modo == 2) q[4] = q[4] ^ 8'($urandom_range(1, 255));
      transacao(5, (modo == 3) ? int'($urandom_range(0, 4)) : 9, 0, 1);
      repeat (3) step();
    end

    repeat (5) step();
    check("queue_drained", fila.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
